pc_update_ctrl: RTL

PC_UPDATE_CTRL -- requirements
Module: pc_update_ctrl

---
 rtl/pc_update_ctrl_if.sv | 24 ++
 rtl/pc_update_ctrl.sv | 76 +++++++
 2 files changed

// File: rtl/pc_update_ctrl_if.sv
// pc_update_ctrl_if: controller strobes, redirect operands and PC/status outputs of pc_update_ctrl.
interface pc_update_ctrl_if;
    logic [31:0] pc4_i;
    logic        fetch_en;
    logic        br_en;
    logic [1:0]  npc_op;
    logic        cond_i;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic [31:0] pc_o;
    logic [31:0] link_o;
    logic        redirect_o;
    logic        misalign_o;
    logic        proto_err_o;
    modport slave (
        input  pc4_i, fetch_en, br_en, npc_op, cond_i, imm16, imm26, rs_data,
        output pc_o, link_o, redirect_o, misalign_o, proto_err_o
    );
    modport master (
        output pc4_i, fetch_en, br_en, npc_op, cond_i, imm16, imm26, rs_data,
        input  pc_o, link_o, redirect_o, misalign_o, proto_err_o
    );
endinterface

// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: registered PC with sequential fetch and one-cycle branch/jump/jr redirect.
module pc_update_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic              clk,
    input logic              reset,
    pc_update_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {READY, IN_FLIGHT, ERR} state_t;
    state_t      r_state, w_nstate;
    logic [31:0] r_pc, r_link, w_pc, w_link;
    logic        r_redir, r_mis, r_perr, w_redir, w_mis, w_perr;
    logic [31:0] w_br_tgt, w_j_tgt, w_tgt;
    logic        w_take, w_bad;
    // Redirect targets are based on link_o, the PC+4 of the instruction in flight.
    assign w_br_tgt = r_link + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign w_j_tgt  = {r_link[31:28], bus.imm26, 2'b00};
    assign w_tgt    = bus.npc_op == 2'b01 ? w_br_tgt : bus.npc_op == 2'b10 ? w_j_tgt : bus.rs_data;
    assign w_bad    = bus.npc_op == 2'b11 && bus.rs_data[1:0] != 2'b00;
    assign w_take   = bus.npc_op == 2'b10 || (bus.npc_op == 2'b11 && !w_bad)
                   || (bus.npc_op == 2'b01 && bus.cond_i);
    always_comb begin
        w_nstate = r_state;
        w_pc     = r_pc;
        w_link   = r_link;
        w_redir  = 1'b0;
        w_mis    = r_mis;
        w_perr   = r_perr;
        case (r_state)
            READY: begin
                if (bus.br_en) begin
                    w_perr = 1'b1;
                end else if (bus.fetch_en) begin
                    w_pc     = bus.pc4_i;
                    w_link   = bus.pc4_i;
                    w_nstate = IN_FLIGHT;
                end
            end
            IN_FLIGHT: begin
                if (bus.br_en) begin
                    w_perr   = r_perr | bus.fetch_en;
                    w_nstate = w_bad ? ERR : READY;
                    w_mis    = r_mis | w_bad;
                    w_pc     = w_take ? w_tgt : r_pc;
                    w_redir  = w_take;
                end else if (bus.fetch_en) begin
                    w_pc   = bus.pc4_i;
                    w_link = bus.pc4_i;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= READY;
            r_pc    <= RESET_PC;
            r_link  <= RESET_PC + 32'd4;
            r_redir <= 1'b0;
            r_mis   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_pc    <= w_pc;
            r_link  <= w_link;
            r_redir <= w_redir;
            r_mis   <= w_mis;
            r_perr  <= w_perr;
        end
    end
    assign bus.pc_o        = r_pc;
    assign bus.link_o      = r_link;
    assign bus.redirect_o  = r_redir;
    assign bus.misalign_o  = r_mis;
    assign bus.proto_err_o = r_perr;
endmodule
